// File: rtl/santim_ctl.sv
// rtl/santim_ctl.sv - sanity-timer controller that arms, reloads and fires the santim BDCOK pulse generator
//
// Purpose:
//   Divides clock_i into timeout ticks (TICK_DIV cycles each) and counts down a
//   host-selected number of ticks. The host keeps the timer alive with kick_i.
//   When the countdown runs out, the generator's enable and generate inputs are
//   held high for GEN_HOLD cycles and a sticky expiry flag is raised.
//
// Ports:
//   clock_i       in   1  clock (2.5 MHz in the target system)
//   reset_i       in   1  synchronous reset, active-high
//   ena_i         in   1  sanity timer enable
//   sel_i         in   3  timeout select, sampled at arm and on each accepted kick
//   kick_i        in   1  single-cycle keep-alive, reloads the countdown
//   santim_ena_o  out  1  to santim ena_i
//   gen_o         out  1  to santim gen_i
//   expired_o     out  1  sticky expiry flag
//   busy_o        out  1  high in ARM, RUN and FIRE
module santim_ctl #(
    parameter int TICK_DIV = 625000,
    parameter int GEN_HOLD = 16
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ena_i,
    input  logic [2:0] sel_i,
    input  logic       kick_i,
    output logic       santim_ena_o,
    output logic       gen_o,
    output logic       expired_o,
    output logic       busy_o
);

    localparam int HW = $clog2(GEN_HOLD) + 1;
    localparam logic [19:0]   DIV_LAST  = 20'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(GEN_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FIRE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [19:0]   r_presc;
    logic [13:0]   r_count;
    logic [HW-1:0] r_hold;
    logic          r_expired;

    logic [13:0]   w_sel_ticks;
    logic          w_tick;
    logic          w_kick;

    // Timeout in 0.25 s ticks: 0.25 s, 1 s, 4 s, 16 s, 1 min, 4 min, 16 min, 64 min.
    always_comb begin
        w_sel_ticks = 14'd1;
        case (sel_i)
            3'd1:    w_sel_ticks = 14'd4;
            3'd2:    w_sel_ticks = 14'd16;
            3'd3:    w_sel_ticks = 14'd64;
            3'd4:    w_sel_ticks = 14'd240;
            3'd5:    w_sel_ticks = 14'd960;
            3'd6:    w_sel_ticks = 14'd3840;
            3'd7:    w_sel_ticks = 14'd15360;
            default: w_sel_ticks = 14'd1;
        endcase
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == DIV_LAST);
    // A kick only counts in RUN and only while enabled; dropping ena_i wins.
    assign w_kick = (r_state == S_RUN) && ena_i && kick_i;

    always_comb begin
        w_next       = r_state;
        santim_ena_o = 1'b0;
        gen_o        = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ena_i) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                busy_o = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (!ena_i) begin
                    w_next = S_IDLE;
                end else if (!kick_i && w_tick && (r_count == 14'd1)) begin
                    // A kick on the final tick reloads instead of firing.
                    w_next = S_FIRE;
                end
            end
            S_FIRE: begin
                busy_o       = 1'b1;
                santim_ena_o = 1'b1;
                gen_o        = 1'b1;
                if (!ena_i) begin
                    w_next = S_IDLE;
                end else if (r_hold == HOLD_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!ena_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign expired_o = r_expired;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_presc   <= 20'd0;
            r_count   <= 14'd0;
            r_hold    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= '0;
            case (r_state)
                S_ARM: begin
                    r_count   <= w_sel_ticks;
                    r_presc   <= 20'd0;
                    r_expired <= 1'b0;
                end
                S_RUN: begin
                    if (w_kick) begin
                        r_count <= w_sel_ticks;
                        r_presc <= 20'd0;
                    end else if (ena_i) begin
                        r_presc <= w_tick ? 20'd0 : r_presc + 20'd1;
                        if (w_tick && (r_count != 14'd1)) begin
                            r_count <= r_count - 14'd1;
                        end
                    end
                    if (w_next == S_FIRE) begin
                        r_expired <= 1'b1;
                    end
                end
                S_FIRE: begin
                    r_hold <= r_hold + HW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_santim_ctl.sv
// tb/tb_santim_ctl.sv - scoreboard bench for santim_ctl
module tb_santim_ctl;

    localparam int TICK_DIV = 4;
    localparam int GEN_HOLD = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       ena   = 1'b0;
    logic       kick  = 1'b0;
    logic [2:0] sel   = 3'd0;
    logic       sena;
    logic       gen;
    logic       expd;
    logic       busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic prev_gen = 1'b0;

    santim_ctl #(
        .TICK_DIV(TICK_DIV),
        .GEN_HOLD(GEN_HOLD)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .ena_i       (ena),
        .sel_i       (sel),
        .kick_i      (kick),
        .santim_ena_o(sena),
        .gen_o       (gen),
        .expired_o   (expd),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic outs(input string tag, input int g, input int e, input int b);
        check({tag, "_gen"}, {31'd0, gen}, g);
        check({tag, "_sena"}, {31'd0, sena}, g);
        check({tag, "_expired"}, {31'd0, expd}, e);
        check({tag, "_busy"}, {31'd0, busy}, b);
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every gen_o rising edge must match the oldest expected rise cycle.
    always @(negedge clk) begin
        if (gen && !prev_gen) begin
            check("gen_rise_cycle", cyc, (exp_q.size() != 0) ? exp_q.pop_front() : -1);
        end
        prev_gen = gen;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int k;
        int r;
        int x;

        @(posedge clk);
        #1;
        goto(3);
        outs("reset", 0, 0, 0);
        rst = 1'b0;
        goto(5);
        outs("idle", 0, 0, 0);

        // Basic expiry, sel=0: FIRE 5 cycles after ARM, held 16 cycles.
        p = cyc;
        ena = 1'b1;
        exp_q.push_back(p + 6);
        goto(p + 1);
        check("arm_busy", {31'd0, busy}, 1);
        goto(p + 5);
        outs("pre_fire", 0, 0, 1);
        goto(p + 6);
        outs("fire_first", 1, 1, 1);
        goto(p + 21);
        outs("fire_last", 1, 1, 1);
        goto(p + 22);
        outs("done", 0, 1, 0);
        goto(p + 23);
        kick = 1'b1;
        goto(p + 24);
        kick = 1'b0;
        goto(p + 26);
        outs("done_kick", 0, 1, 0);
        ena = 1'b0;
        goto(p + 28);
        outs("idle_after_expiry", 0, 1, 0);

        // Keep-alive, sel=2 (16 ticks = 64 cycles), kicks every 40 cycles.
        p = cyc;
        sel = 3'd2;
        ena = 1'b1;
        k = p;
        for (int i = 0; i < 12; i++) begin
            k = p + 10 + 40 * i;
            goto(k);
            kick = 1'b1;
            goto(k + 1);
            kick = 1'b0;
            check("kept_alive_expired", {31'd0, expd}, 0);
        end
        exp_q.push_back(k + 65);
        goto(k + 64);
        outs("last_kick_pre", 0, 0, 1);
        goto(k + 65);
        outs("last_kick_fire", 1, 1, 1);
        ena = 1'b0;
        goto(k + 67);

        // Kick coincident with the final tick: reload from new sel (1 -> 4 ticks).
        p = cyc;
        sel = 3'd0;
        ena = 1'b1;
        k = p + 5;
        goto(k);
        kick = 1'b1;
        sel = 3'd1;
        exp_q.push_back(k + 17);
        goto(k + 1);
        kick = 1'b0;
        outs("final_tick_kick", 0, 0, 1);
        check("final_tick_reload", 32'(dut.r_count), 4);
        goto(k + 2);
        check("final_tick_nofire", {31'd0, gen}, 0);
        r = k + 17;
        goto(r);
        outs("reloaded_fire", 1, 1, 1);

        // ena_i dropped at hold cycle 5, then re-armed.
        goto(r + 5);
        ena = 1'b0;
        goto(r + 6);
        outs("fire_abort", 0, 1, 0);
        ena = 1'b1;
        goto(r + 7);
        check("rearm_busy", {31'd0, busy}, 1);
        goto(r + 8);
        outs("rearm_run", 0, 0, 1);

        // Reset during RUN, then during DONE, with ena_i held high.
        x = r + 10;
        goto(x);
        rst = 1'b1;
        sel = 3'd0;
        goto(x + 1);
        rst = 1'b0;
        outs("reset_run", 0, 0, 0);
        exp_q.push_back(x + 7);
        goto(x + 2);
        check("reset_run_rearm", {31'd0, busy}, 1);
        goto(x + 22);
        outs("reset_fire_last", 1, 1, 1);
        goto(x + 23);
        outs("reset_done", 0, 1, 0);
        goto(x + 25);
        rst = 1'b1;
        goto(x + 26);
        rst = 1'b0;
        outs("reset_in_done", 0, 0, 0);
        goto(x + 27);
        check("reset_done_rearm", {31'd0, busy}, 1);
        ena = 1'b0;
        goto(x + 30);
        check("disable_idle", {31'd0, busy}, 0);

        // sel 0 -> 7 mid-RUN without kick: expiry still after 1 tick.
        p = cyc;
        sel = 3'd0;
        ena = 1'b1;
        exp_q.push_back(p + 6);
        goto(p + 3);
        sel = 3'd7;
        goto(p + 6);
        outs("sel_change_fire", 1, 1, 1);
        goto(p + 22);
        outs("sel_change_done", 0, 1, 0);
        ena = 1'b0;
        goto(p + 24);

        // sel 0 -> 7 then kick: 15360-tick reload.
        p = cyc;
        sel = 3'd0;
        ena = 1'b1;
        goto(p + 3);
        sel = 3'd7;
        kick = 1'b1;
        goto(p + 4);
        kick = 1'b0;
        goto(p + 5);
        check("sel7_reload", 32'(dut.r_count), 15360);
        goto(p + 40);
        outs("sel7_running", 0, 0, 1);
        ena = 1'b0;
        goto(p + 43);
        check("sel7_disabled", {31'd0, busy}, 0);

        check("pending_rises", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
